program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Front-end for the programmable processor: accepts a stream of 16-bit instruction words
//  over a valid/ready handshake, writes them into instruction memory from address 0, then
//  releases the processor's active-low reset and watches the processor's IR for the halt
//  word. The processor is held in reset for the whole load. Done flags completion.
// PARAMETERS
//  ADDR_W     7         instruction-memory address width (matches PC width)
//  DATA_W     16        instruction word width
//  HALT_WORD  16'h5000  IR value that marks program completion
// PORTS
//  Clk         in   1         system clock, rising edge
//  Reset       in   1         async active-low reset
//  Load_Start  in   1         request new load; sampled at the clock edge
//  Load_Len    in   ADDR_W+1  number of words to load; legal range 1..2**ADDR_W
//  In_Data     in   DATA_W    instruction word
//  In_Valid    in   1         In_Data valid
//  In_Ready    out  1         loader accepts a word this cycle
//  IM_Addr     out  ADDR_W    instruction-memory write address
//  IM_Data     out  DATA_W    instruction-memory write data
//  IM_Wr       out  1         instruction-memory write enable
//  CPU_Reset   out  1         processor reset, active-low (0 = processor held)
//  IR_In       in   DATA_W    processor IR_Out
//  Busy        out  1         load in progress
//  Halted      out  1         processor reached HALT_WORD (sticky until next load)
//  Done        out  1         one-cycle pulse when halt is detected
//  Err         out  1         one-cycle pulse on an illegal Load_Len
// BEHAVIOUR
//  Reset (async, Reset=0): state IDLE.
//   - All outputs are 0, including CPU_Reset=0, so the processor is held in reset.
//   - The word counter clears to 0.
//  FSM states: IDLE, LOAD, RELEASE, RUN, HALT. All outputs are registered except In_Ready.
//  In_Ready = (state==LOAD). A transfer occurs on a rising edge with In_Valid & In_Ready.
//  IDLE: CPU_Reset=0.
//   - Load_Start with Load_Len in 1..2**ADDR_W: latch Load_Len, clear count, go to LOAD.
//   - Load_Start with Load_Len=0 or >2**ADDR_W: Err=1 for one cycle, stay in IDLE,
//     no writes.
//  LOAD: Busy=1. Halted is cleared on entry.
//   - On each transfer: next cycle IM_Wr=1, IM_Addr=count[ADDR_W-1:0], IM_Data=In_Data.
//     Then count increments.
//   - With no transfer, IM_Wr=0 the next cycle.
//   - At the transfer with count==len-1, go to RELEASE. No further In_Ready is given.
//   - Load_Start is ignored.
//  RELEASE: one cycle. Busy=1, IM_Wr carries the last word. Then go to RUN.
//   - CPU_Reset is set to 1 at that edge.
//   - Last handshake at edge N -> last IM_Wr during N..N+1 -> CPU_Reset=1 from edge N+1.
//  RUN: Busy=0, CPU_Reset=1.
//   - IR_In is ignored in the first RUN cycle (blanking while the processor leaves reset).
//   - From then on, IR_In==HALT_WORD at an edge sets Halted=1, pulses Done=1 for one
//     cycle, and goes to HALT.
//  HALT: CPU_Reset stays 1 and Halted stays 1.
//  Load_Start in RUN or HALT, with a legal Load_Len:
//   - CPU_Reset=0 at the next edge, go to LOAD, count=0.
//   - Illegal Load_Len: Err pulse, state unchanged.
//  Boundaries:
//   - Load_Len=2**ADDR_W writes addresses 0..2**ADDR_W-1 and never wraps to 0.
//   - count is ADDR_W+1 bits wide.
//   - Load_Start together with an Err condition never causes an IM_Wr.
//   - Async Reset mid-LOAD immediately drops IM_Wr and In_Ready and drives CPU_Reset=0.
//     Partially written memory contents are unspecified.
// TESTING
//  1. Reset=0 then 1; Load_Start, Len=3; words 16'h1111, 16'h2222, 16'h5000 with In_Valid
//     held high -> IM_Wr at addr 0,1,2 with matching data. CPU_Reset=1 one edge after the
//     last IM_Wr. Busy low in RUN.
//  2. Len=4 with In_Valid toggling every other cycle -> exactly 4 writes at contiguous
//     addresses 0..3, no duplicates, In_Ready low after the 4th transfer.
//  3. Len=0, then Len=129 -> one-cycle Err pulse each, no IM_Wr, state IDLE,
//     CPU_Reset stays 0.
//  4. In RUN: IR_In=16'h5000 in the first cycle is ignored. Then 16'h1234, then 16'h5000
//     -> Halted=1 and one-cycle Done at that edge.
//  5. Reset=0 after 2 of 5 words -> all outputs 0 immediately, no further writes.
//     After Reset=1, a new Len=2 load starts at addr 0.
//  6. Len=128 -> last write at addr 7F, 128 writes total. Load_Start during LOAD is
//     ignored. Load_Start in HALT -> CPU_Reset=0 next edge, Halted cleared,
//     reload starts at addr 0.

Source files
------------

// File: rtl/program_loader_if.sv
// Instruction stream (valid/ready) and instruction-memory write port between
// the program source, the loader and the instruction memory.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] IM_Addr;
  logic [DATA_W-1:0] IM_Data;
  logic              IM_Wr;

  modport master (
    output In_Data, In_Valid,
    input  In_Ready, IM_Addr, IM_Data, IM_Wr
  );

  modport slave (
    input  In_Data, In_Valid,
    output In_Ready, IM_Addr, IM_Data, IM_Wr
  );
endinterface

// File: rtl/program_loader.sv
// Streams a program into instruction memory while the processor is held in reset,
// then releases the processor and watches its IR for the halt word.
module program_loader #(
  parameter int unsigned       ADDR_W    = 7,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h5000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_Start,
  input  logic [ADDR_W:0]   Load_Len,
  program_loader_if.slave   bus,
  output logic              CPU_Reset,
  input  logic [DATA_W-1:0] IR_In,
  output logic              Busy,
  output logic              Halted,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [2:0] {StIdle, StLoad, StRelease, StRun, StHalt} state_e;

  localparam logic [ADDR_W:0] LenMax = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              blank_q, blank_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              im_wr_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [DATA_W-1:0] im_data_q;
  logic              len_ok;
  logic              xfer;

  assign len_ok = (Load_Len != '0) && (Load_Len <= LenMax);
  assign xfer   = bus.In_Valid && (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    blank_d = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StRun, StHalt: begin
        if (Load_Start) begin
          if (len_ok) begin
            len_d   = Load_Len;
            count_d = '0;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end else if (state_q == StRun && !blank_q && IR_In == HALT_WORD) begin
          state_d = StHalt;
          done_d  = 1'b1;
        end
      end
      StLoad: begin
        if (xfer) begin
          count_d = count_q + 1'b1;
          if (count_q == len_q - 1'b1) begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        state_d = StRun;
        // The processor is still leaving reset in its first cycle; its IR is stale.
        blank_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      len_q     <= '0;
      blank_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      im_wr_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      done_q  <= done_d;
      im_wr_q <= xfer;
      if (xfer) begin
        im_addr_q <= count_q[ADDR_W-1:0];
        im_data_q <= bus.In_Data;
      end
    end
  end

  assign bus.In_Ready = (state_q == StLoad);
  assign bus.IM_Wr    = im_wr_q;
  assign bus.IM_Addr  = im_addr_q;
  assign bus.IM_Data  = im_data_q;
  assign Busy         = (state_q == StLoad) || (state_q == StRelease);
  assign CPU_Reset    = (state_q == StRun) || (state_q == StHalt);
  assign Halted       = (state_q == StHalt);
  assign Done         = done_q;
  assign Err          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a transaction-level model predicts every
// output each cycle, and literal checks pin the key scenarios.
module tb_program_loader;
  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 16;
  localparam logic [15:0] HALT = 16'h5000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Load_Start = 1'b0;
  logic [AW:0]   Load_Len = '0;
  logic          CPU_Reset;
  logic [DW-1:0] IR_In = '0;
  logic          Busy, Halted, Done, Err;

  program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  program_loader #(.ADDR_W(AW), .DATA_W(DW), .HALT_WORD(HALT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load_Start (Load_Start),
    .Load_Len   (Load_Len),
    .bus        (bus),
    .CPU_Reset  (CPU_Reset),
    .IR_In      (IR_In),
    .Busy       (Busy),
    .Halted     (Halted),
    .Done       (Done),
    .Err        (Err)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words still owed, next address, release cycle, processor running age.
  int          m_rem = 0;
  int          m_addr = 0;
  bit          m_rel = 0;
  bit          m_cpu = 0;
  bit          m_halt = 0;
  int          m_age = 0;
  bit          e_wr, e_err, e_done;
  int          e_addr;
  logic [15:0] e_data;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  int          last_wr_cyc = 0;
  int          cpu_rise_cyc = 0;
  bit          cpu_prev = 0;
  logic [15:0] dut_mem [128];
  logic [15:0] words [$];

  always @(posedge Clk) begin
    cyc++;
    e_wr = 0;
    e_err = 0;
    e_done = 0;
    if (!Reset) begin
      m_rem = 0; m_addr = 0; m_rel = 0; m_cpu = 0; m_halt = 0; m_age = 0;
    end else if (m_rem > 0) begin
      if (bus.In_Valid) begin
        e_wr = 1; e_addr = m_addr; e_data = bus.In_Data;
        m_addr++;
        m_rem--;
        if (m_rem == 0) m_rel = 1;
      end
    end else if (m_rel) begin
      m_rel = 0; m_cpu = 1; m_age = 0;
    end else if (Load_Start) begin
      if (int'(Load_Len) >= 1 && int'(Load_Len) <= 128) begin
        m_rem = int'(Load_Len); m_addr = 0; m_cpu = 0; m_halt = 0;
      end else begin
        e_err = 1;
      end
    end else if (m_cpu && !m_halt) begin
      if (m_age >= 1 && IR_In == HALT) begin
        m_halt = 1; e_done = 1;
      end
      m_age++;
    end
    #1;
    check("in_ready", 32'(bus.In_Ready), 32'(m_rem > 0));
    check("busy", 32'(Busy), 32'(m_rem > 0 || m_rel));
    check("cpu_reset", 32'(CPU_Reset), 32'(m_cpu));
    check("halted", 32'(Halted), 32'(m_halt));
    check("done", 32'(Done), 32'(e_done));
    check("err", 32'(Err), 32'(e_err));
    check("im_wr", 32'(bus.IM_Wr), 32'(e_wr));
    if (e_wr) begin
      check("im_addr", 32'(bus.IM_Addr), 32'(e_addr));
      check("im_data", 32'(bus.IM_Data), 32'(e_data));
    end
    if (bus.IM_Wr === 1'b1) begin
      wr_cnt++;
      dut_mem[bus.IM_Addr] = bus.IM_Data;
      last_wr = int'(bus.IM_Addr);
      if (first_wr < 0) first_wr = int'(bus.IM_Addr);
      last_wr_cyc = cyc;
    end
    if (CPU_Reset && !cpu_prev) cpu_rise_cyc = cyc;
    cpu_prev = CPU_Reset;
  end

  task automatic start_load(input int len);
    @(negedge Clk);
    Load_Start = 1'b1;
    Load_Len   = (AW+1)'(len);
    @(negedge Clk);
    Load_Start = 1'b0;
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    first_wr = -1;
    last_wr = -1;
  endtask

  // Offers words[0..n-1]; gap toggles In_Valid; ls_at pulses Load_Start mid-load.
  task automatic send_words(input int n, input bit gap, input int ls_at, input int timeout);
    int i = 0;
    int c = 0;
    bit v = 1;
    while (i < n && c < timeout) begin
      @(negedge Clk);
      bus.In_Valid = v;
      bus.In_Data  = words[i];
      Load_Start   = (i == ls_at);
      Load_Len     = 8'd3;
      if (v && bus.In_Ready) i++;
      if (gap) v = !v;
      c++;
    end
    @(negedge Clk);
    bus.In_Valid = 1'b0;
    Load_Start   = 1'b0;
    if (i < n) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_cpu(input int timeout);
    int c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (!CPU_Reset && c < timeout);
    if (!CPU_Reset) check("cpu_release_timeout", 32'(CPU_Reset), 32'd1);
  endtask

  initial begin
    bus.In_Valid = 1'b0;
    bus.In_Data  = '0;
    repeat (2) @(negedge Clk);
    check("rst_cpu_reset", 32'(CPU_Reset), 32'd0);
    check("rst_in_ready", 32'(bus.In_Ready), 32'd0);
    check("rst_im_wr", 32'(bus.IM_Wr), 32'd0);
    Reset = 1'b1;

    // Three words with In_Valid held high, then the halt sequence.
    clear_log();
    words = '{16'h1111, 16'h2222, 16'h5000};
    start_load(3);
    check("t1_busy_load", 32'(Busy), 32'd1);
    send_words(3, 0, -1, 20);
    wait_cpu(20);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t1_mem0", 32'(dut_mem[0]), 32'h1111);
    check("t1_mem1", 32'(dut_mem[1]), 32'h2222);
    check("t1_mem2", 32'(dut_mem[2]), 32'h5000);
    check("t1_release_gap", 32'(cpu_rise_cyc - last_wr_cyc), 32'd1);
    check("t1_busy_run", 32'(Busy), 32'd0);
    IR_In = HALT;
    @(negedge Clk);
    IR_In = 16'h1234;
    check("t4_blank_ignored", 32'(Halted), 32'd0);
    @(negedge Clk);
    IR_In = HALT;
    @(negedge Clk);
    IR_In = '0;
    check("t4_halted", 32'(Halted), 32'd1);
    check("t4_done", 32'(Done), 32'd1);
    @(negedge Clk);
    check("t4_done_pulse", 32'(Done), 32'd0);
    check("t4_halted_sticky", 32'(Halted), 32'd1);

    // Illegal lengths from IDLE.
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    clear_log();
    start_load(0);
    check("t3_err_len0", 32'(Err), 32'd1);
    @(negedge Clk);
    check("t3_err_pulse", 32'(Err), 32'd0);
    start_load(129);
    check("t3_err_len129", 32'(Err), 32'd1);
    repeat (3) @(negedge Clk);
    check("t3_no_writes", 32'(wr_cnt), 32'd0);
    check("t3_idle", 32'(Busy), 32'd0);
    check("t3_cpu_held", 32'(CPU_Reset), 32'd0);

    // Four words with a bursty source; extra valids afterwards must be refused.
    clear_log();
    words = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    start_load(4);
    send_words(4, 1, -1, 40);
    check("t2_ready_low", 32'(bus.In_Ready), 32'd0);
    bus.In_Valid = 1'b1;
    repeat (4) @(negedge Clk);
    bus.In_Valid = 1'b0;
    check("t2_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t2_first", 32'(first_wr), 32'd0);
    check("t2_last", 32'(last_wr), 32'd3);
    check("t2_mem3", 32'(dut_mem[3]), 32'hD4D4);

    // Reset after two of five words.
    clear_log();
    words = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    start_load(5);
    send_words(2, 0, -1, 20);
    check("t5_wr_before_rst", 32'(bus.IM_Wr), 32'd1);
    Reset = 1'b0;
    #1;
    check("t5_rst_im_wr", 32'(bus.IM_Wr), 32'd0);
    check("t5_rst_ready", 32'(bus.In_Ready), 32'd0);
    check("t5_rst_busy", 32'(Busy), 32'd0);
    check("t5_rst_cpu", 32'(CPU_Reset), 32'd0);
    bus.In_Valid = 1'b1;
    repeat (3) @(negedge Clk);
    bus.In_Valid = 1'b0;
    check("t5_no_more_writes", 32'(wr_cnt), 32'd2);
    Reset = 1'b1;
    clear_log();
    words = '{16'h7777, 16'h8888};
    start_load(2);
    send_words(2, 0, -1, 20);
    wait_cpu(20);
    check("t5_first", 32'(first_wr), 32'd0);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t5_mem1", 32'(dut_mem[1]), 32'h8888);

    // Full-size load, Load_Start ignored mid-load, then reload from HALT.
    clear_log();
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(16'hA000 + 16'(i));
    start_load(128);
    send_words(128, 0, 10, 400);
    wait_cpu(20);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd128);
    check("t6_first", 32'(first_wr), 32'd0);
    check("t6_last", 32'(last_wr), 32'h7F);
    check("t6_mem0", 32'(dut_mem[0]), 32'hA000);
    check("t6_mem127", 32'(dut_mem[127]), 32'hA07F);
    IR_In = HALT;
    repeat (3) @(negedge Clk);
    IR_In = '0;
    check("t6_halted", 32'(Halted), 32'd1);
    start_load(200);
    check("t6_err_in_halt", 32'(Err), 32'd1);
    check("t6_still_halted", 32'(Halted), 32'd1);
    clear_log();
    words = '{16'h3333, 16'h4444};
    start_load(2);
    check("t6_reload_cpu_held", 32'(CPU_Reset), 32'd0);
    check("t6_reload_halted_clr", 32'(Halted), 32'd0);
    check("t6_reload_busy", 32'(Busy), 32'd1);
    send_words(2, 0, -1, 20);
    wait_cpu(20);
    check("t6_reload_first", 32'(first_wr), 32'd0);
    check("t6_reload_mem0", 32'(dut_mem[0]), 32'h3333);

    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
